// File: rtl/bit_demux_deser_if.sv
// bit_demux_deser_if: serial-in / byte-out bundle between a bit source and the deserializer.
//   din, din_valid, frame_start : serial bit stream and framing from the source
//   sel_out                     : index of the next expected bit (mux-select counterpart)
//   data_out, out_valid         : assembled byte and its valid flag
//   out_ready                   : consumer acceptance of data_out
//   busy, parity_err            : collection in progress, parity result for data_out
interface bit_demux_deser_if;
    logic       din;
    logic       din_valid;
    logic       frame_start;
    logic [2:0] sel_out;
    logic [7:0] data_out;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       parity_err;
    modport master (
        output din, din_valid, frame_start, out_ready,
        input  sel_out, data_out, out_valid, busy, parity_err
    );
    modport slave (
        input  din, din_valid, frame_start, out_ready,
        output sel_out, data_out, out_valid, busy, parity_err
    );
endinterface

// File: rtl/bit_demux_deser.sv
// bit_demux_deser: collects 8 serial bits into a byte and holds it until the consumer accepts.
//   clk, rst : clock and asynchronous active-high reset
//   s        : bit_demux_deser_if slave (serial input, byte output, handshake, status)
//   LSB_FIRST: 1 = first bit lands in data_out[0], 0 = first bit lands in data_out[7]
//   Define PARITY_CHECK_EN to take a 9th even-parity bit per frame and report parity_err.
module bit_demux_deser #(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    bit_demux_deser_if.slave   s
);
`ifdef PARITY_CHECK_EN
    typedef enum logic [1:0] {IDLE, COLLECT, PARITY, HOLD} state_t;
`else
    typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;
`endif
    state_t     state, state_nx;
    logic [2:0] idx, pos;
    logic [7:0] shreg, shreg_w, data_q;
    logic       valid_q, accept, restart;
`ifdef PARITY_CHECK_EN
    logic       perr_q, pbit;
`endif
    always_comb begin
        pos = LSB_FIRST ? idx : 3'd7 - idx;
        shreg_w = shreg;
        shreg_w[pos] = s.din;
        // A held byte may only be abandoned once the consumer has taken it.
        restart = s.frame_start && (state != HOLD || s.out_ready);
        accept = state == COLLECT && s.din_valid && !s.frame_start;
`ifdef PARITY_CHECK_EN
        pbit = state == PARITY && s.din_valid && !s.frame_start;
`endif
        state_nx = state;
        case (state)
            IDLE:    state_nx = s.frame_start ? COLLECT : IDLE;
`ifdef PARITY_CHECK_EN
            COLLECT: state_nx = accept && idx == 3'd7 ? PARITY : COLLECT;
            PARITY:  state_nx = s.frame_start ? COLLECT : pbit ? HOLD : PARITY;
`else
            COLLECT: state_nx = accept && idx == 3'd7 ? HOLD : COLLECT;
`endif
            HOLD:    state_nx = s.out_ready ? (s.frame_start ? COLLECT : IDLE) : HOLD;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_nx;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= 3'd0;
            shreg <= 8'h00;
            data_q <= 8'h00;
            valid_q <= 1'b0;
`ifdef PARITY_CHECK_EN
            perr_q <= 1'b0;
`endif
        end else begin
            if (restart) begin
                idx <= 3'd0;
                shreg <= 8'h00;
            end else if (accept) begin
                idx <= idx + 3'd1;
                shreg <= shreg_w;
            end
`ifdef PARITY_CHECK_EN
            if (pbit) begin
                data_q <= shreg;
                perr_q <= ^{shreg, s.din};
                valid_q <= 1'b1;
            end
`else
            // Publish the byte with the 8th bit merged in, one clock after it arrives.
            if (accept && idx == 3'd7) begin
                data_q <= shreg_w;
                valid_q <= 1'b1;
            end
`endif
            if (state == HOLD && s.out_ready) valid_q <= 1'b0;
        end
    end
    assign s.sel_out = state == COLLECT ? idx : 3'd0;
    assign s.data_out = data_q;
    assign s.out_valid = valid_q;
`ifdef PARITY_CHECK_EN
    assign s.busy = state == COLLECT || state == PARITY;
    assign s.parity_err = perr_q;
`else
    assign s.busy = state == COLLECT;
    assign s.parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_bit_demux_deser.sv
// tb_bit_demux_deser: randomized self-checking bench for bit_demux_deser against a byte-level model.
module tb_bit_demux_deser;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;
    logic [7:0] last = 8'h00;
    localparam bit LSB = 1'b1;
`ifdef PARITY_CHECK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    bit_demux_deser_if bus ();
    bit_demux_deser #(.LSB_FIRST(LSB)) dut (.clk(clk), .rst(rst), .s(bus.slave));
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic bit_for(input logic [7:0] b, input int k);
        return LSB ? b[k] : b[7-k];
    endfunction

    task automatic start_frame;
        bus.frame_start = 1'b1;
        bus.din_valid = 1'b0;
        tick();
        bus.frame_start = 1'b0;
        total++;
        if (bus.busy !== 1'b1 || bus.sel_out !== 3'd0)
            $display("FAIL start busy=%b sel=%0d want busy=1 sel=0", bus.busy, bus.sel_out);
        if (bus.busy !== 1'b1 || bus.sel_out !== 3'd0) bad++;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_at, input int gap_len, input logic par);
        logic exp_perr;
        exp_perr = PAR_EN ? ((^b) ^ par) : 1'b0;
        for (int k = 0; k < 8; k++) begin
            for (int g = 0; g < ((k == gap_at) ? gap_len : 0); g++) begin
                bus.din_valid = 1'b0;
                bus.din = 1'($urandom);
                tick();
                total++;
                if (bus.sel_out !== 3'(k)) begin
                    bad++;
                    $display("FAIL gap_sel got=%0d want=%0d", bus.sel_out, k);
                end
            end
            bus.din = bit_for(b, k);
            bus.din_valid = 1'b1;
            total++;
            if (bus.sel_out !== 3'(k) || bus.busy !== 1'b1 || bus.out_valid !== 1'b0) begin
                bad++;
                $display("FAIL sel_step sel=%0d busy=%b ov=%b want sel=%0d busy=1 ov=0",
                         bus.sel_out, bus.busy, bus.out_valid, k);
            end
            tick();
        end
        bus.din_valid = 1'b0;
`ifdef PARITY_CHECK_EN
        total++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL parity_wait ov=%b busy=%b want ov=0 busy=1", bus.out_valid, bus.busy);
        end
        bus.din = par;
        bus.din_valid = 1'b1;
        tick();
        bus.din_valid = 1'b0;
`endif
        total++;
        if (bus.out_valid !== 1'b1) begin
            bad++;
            $display("FAIL done_valid got=%b want=1", bus.out_valid);
        end
        total++;
        if (bus.data_out !== b) begin
            bad++;
            $display("FAIL done_data got=%h want=%h", bus.data_out, b);
        end
        total++;
        if (bus.parity_err !== exp_perr) begin
            bad++;
            $display("FAIL parity_err got=%b want=%b", bus.parity_err, exp_perr);
        end
        total++;
        if (bus.busy !== 1'b0 || bus.sel_out !== 3'd0) begin
            bad++;
            $display("FAIL hold_status busy=%b sel=%0d want busy=0 sel=0", bus.busy, bus.sel_out);
        end
        last = b;
    endtask

    task automatic drain(input int wait_n, input logic [7:0] b, input logic pulse_fs);
        bus.out_ready = 1'b0;
        for (int i = 0; i < wait_n; i++) begin
            bus.frame_start = pulse_fs && (i == wait_n / 2);
            bus.din_valid = 1'($urandom);
            bus.din = 1'($urandom);
            tick();
            total++;
            if (bus.out_valid !== 1'b1 || bus.data_out !== b || bus.busy !== 1'b0) begin
                bad++;
                $display("FAIL hold_stable ov=%b data=%h busy=%b want ov=1 data=%h busy=0",
                         bus.out_valid, bus.data_out, bus.busy, b);
            end
        end
        bus.frame_start = 1'b0;
        bus.din_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        total++;
        if (bus.out_valid !== 1'b0 || bus.data_out !== b || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL handshake ov=%b data=%h busy=%b want ov=0 data=%h busy=0",
                     bus.out_valid, bus.data_out, bus.busy, b);
        end
    endtask

    task automatic test_reset;
        tick();
        total++;
        if ({bus.out_valid, bus.data_out, bus.sel_out, bus.busy, bus.parity_err} !== 14'd0) begin
            bad++;
            $display("FAIL reset_state ov=%b data=%h sel=%0d busy=%b perr=%b want all 0",
                     bus.out_valid, bus.data_out, bus.sel_out, bus.busy, bus.parity_err);
        end
        rst = 1'b0;
        start_frame();
        for (int j = 0; j < 3; j++) begin
            bus.din_valid = 1'b1;
            bus.din = 1'($urandom);
            tick();
        end
        bus.din_valid = 1'b0;
        total++;
        if (bus.sel_out !== 3'd3) begin
            bad++;
            $display("FAIL mid_sel got=%0d want=3", bus.sel_out);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if ({bus.out_valid, bus.data_out, bus.sel_out, bus.busy, bus.parity_err} !== 14'd0) begin
            bad++;
            $display("FAIL async_reset ov=%b data=%h sel=%0d busy=%b perr=%b want all 0",
                     bus.out_valid, bus.data_out, bus.sel_out, bus.busy, bus.parity_err);
        end
        tick();
        rst = 1'b0;
        start_frame();
        send_byte(8'hA5, -1, 0, 1'b0);
        drain(2, 8'hA5, 1'b0);
    endtask

    task automatic test_lsb_first;
        start_frame();
        send_byte(8'hA5, -1, 0, 1'b0);
        drain(0, 8'hA5, 1'b0);
        start_frame();
        send_byte(8'hA5, -1, 0, 1'b1);
        drain(1, 8'hA5, 1'b0);
    endtask

    task automatic test_gapped;
        start_frame();
        send_byte(8'h3C, 4, 2, 1'($urandom));
        drain(1, 8'h3C, 1'b0);
    endtask

    task automatic test_idle_ignore;
        for (int i = 0; i < 6; i++) begin
            bus.din_valid = 1'($urandom);
            bus.din = 1'($urandom);
            tick();
            total++;
            if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.data_out !== last) begin
                bad++;
                $display("FAIL idle_ignore busy=%b ov=%b data=%h want busy=0 ov=0 data=%h",
                         bus.busy, bus.out_valid, bus.data_out, last);
            end
        end
        bus.din_valid = 1'b0;
    endtask

    task automatic test_back_to_back;
        start_frame();
        send_byte(8'hA5, -1, 0, 1'b0);
        drain(10, 8'hA5, 1'b1);
        start_frame();
        send_byte(8'hA5, -1, 0, 1'b0);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.frame_start = (i == 3 || i == 7);
            tick();
            total++;
            if (bus.out_valid !== 1'b1 || bus.data_out !== 8'hA5 || bus.busy !== 1'b0) begin
                bad++;
                $display("FAIL backpressure ov=%b data=%h busy=%b want ov=1 data=a5 busy=0",
                         bus.out_valid, bus.data_out, bus.busy);
            end
        end
        bus.out_ready = 1'b1;
        bus.frame_start = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        bus.frame_start = 1'b0;
        total++;
        if (bus.busy !== 1'b1 || bus.sel_out !== 3'd0 || bus.out_valid !== 1'b0 || bus.data_out !== 8'hA5) begin
            bad++;
            $display("FAIL ready_restart busy=%b sel=%0d ov=%b data=%h want busy=1 sel=0 ov=0 data=a5",
                     bus.busy, bus.sel_out, bus.out_valid, bus.data_out);
        end
        send_byte(8'hFF, -1, 0, 1'b0);
        drain(1, 8'hFF, 1'b0);
    endtask

    task automatic test_restart;
        start_frame();
        for (int j = 0; j < 5; j++) begin
            bus.din_valid = 1'b1;
            bus.din = 1'($urandom);
            tick();
        end
        total++;
        if (bus.sel_out !== 3'd5) begin
            bad++;
            $display("FAIL partial_sel got=%0d want=5", bus.sel_out);
        end
        bus.frame_start = 1'b1;
        bus.din_valid = 1'b1;
        bus.din = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        bus.din_valid = 1'b0;
        total++;
        if (bus.sel_out !== 3'd0 || bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL restart_drop sel=%0d busy=%b want sel=0 busy=1", bus.sel_out, bus.busy);
        end
        send_byte(8'h81, -1, 0, 1'b0);
        drain(0, 8'h81, 1'b0);
    endtask

    task automatic test_random;
        logic [7:0] b;
        for (int n = 0; n < 25; n++) begin
            b = 8'($urandom);
            start_frame();
            if ($urandom_range(0, 3) == 0) begin
                for (int j = 0; j < int'($urandom_range(1, 7)); j++) begin
                    bus.din_valid = 1'b1;
                    bus.din = 1'($urandom);
                    tick();
                end
                bus.din_valid = 1'b0;
                start_frame();
            end
            send_byte(b, int'($urandom_range(0, 8)), int'($urandom_range(0, 3)), 1'($urandom));
            drain(int'($urandom_range(0, 4)), b, 1'($urandom));
        end
    endtask

    initial begin
        bus.din = 1'b0;
        bus.din_valid = 1'b0;
        bus.frame_start = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_lsb_first();
        test_gapped();
        test_idle_ignore();
        test_back_to_back();
        test_restart();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
